// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/sub arbiter slice.
//   ST_*      : FSM state encodings (IDLE, EXEC, RESP)
//   MODE_*    : operation select presented to the addsub datapath
//   ADDSUB_W  : operand width of the shared datapath
package addsub_arbiter_pkg;

  localparam int ADDSUB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_EXEC = ST_EXEC,
    S_RESP = ST_RESP
  } state_t;

endpackage

// File: rtl/addsub_arbiter_addsub.sv
// addsub: combinational 4-bit adder/subtractor (shared datapath).
//   m : 0 = add, 1 = subtract (a - b computed as a + ~b + 1)
//   a : operand A, bit 0 is the MSB
//   b : operand B, bit 0 is the MSB
//   s : sum/difference modulo 2^4, bit 0 is the MSB
//   c : carry out of the MSB (subtract: 1 means no borrow)
//   o : signed overflow (carry into MSB differs from carry out of MSB)
module addsub
  import addsub_arbiter_pkg::*;
(
  input  logic                m,
  input  logic [ADDSUB_W-1:0] a,
  input  logic [ADDSUB_W-1:0] b,
  output logic [ADDSUB_W-1:0] s,
  output logic                c,
  output logic                o
);

  logic [ADDSUB_W-1:0] bx;
  // cy[k] is the carry into significance k (k = 0 is the LSB, which sits at
  // bus index ADDSUB_W-1 because bit 0 of the bus carries the MSB).
  logic [ADDSUB_W:0]   cy;

  always_comb begin
    bx    = (m == MODE_SUB) ? ~b : b;
    s     = '0;
    cy    = '0;
    cy[0] = (m != MODE_ADD);
    for (int k = 0; k < ADDSUB_W; k++) begin
      s[ADDSUB_W-1-k] = a[ADDSUB_W-1-k] ^ bx[ADDSUB_W-1-k] ^ cy[k];
      cy[k+1]         = (a[ADDSUB_W-1-k] & bx[ADDSUB_W-1-k])
                      | (cy[k] & (a[ADDSUB_W-1-k] ^ bx[ADDSUB_W-1-k]));
    end
  end

  assign c = cy[ADDSUB_W];
  assign o = cy[ADDSUB_W] ^ cy[ADDSUB_W-1];

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shares one addsub datapath between two requesters.
// Each operation runs IDLE (grant + operand capture) -> EXEC (datapath
// evaluates registered operands, result registered) -> RESP (result held
// until the consumer takes it). Priority flips to the losing requester
// only when a response completes.
//   clk, rst_n                       : clock, async active-low reset
//   reqN_valid/ready                 : request handshake, N = 0, 1
//   reqN_mode/a/b                    : operation and operands (bit 0 = MSB)
//   rsp_valid/ready                  : response handshake
//   rsp_id, rsp_s, rsp_c, rsp_o      : owner, result, carry, overflow
//   busy                             : high whenever not in IDLE
// W must equal the datapath width (4); other values are unsupported.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int W        = 4,
  parameter bit RST_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_mode,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_mode,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_s,
  output logic         rsp_c,
  output logic         rsp_o,
  output logic         busy
);

  state_t       state;
  logic         prio;

  logic         op_mode_p0;
  logic [W-1:0] op_a_p0;
  logic [W-1:0] op_b_p0;
  logic         op_id_p0;

  logic [W-1:0] dp_s;
  logic         dp_c;
  logic         dp_o;

  logic         idle;
  logic         sel1;
  logic         any_grant;

  // rst_n gates the grant so no ready is shown while reset is held.
  assign idle       = (state == S_IDLE) && rst_n;
  assign sel1       = req1_valid && (!req0_valid || prio);
  assign any_grant  = idle && (req0_valid || req1_valid);
  assign req0_ready = any_grant && !sel1;
  assign req1_ready = any_grant && sel1;

  assign rsp_valid  = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  // Stage p0 -> datapath: only registered operands reach the adder.
  addsub u_addsub (
    .m (op_mode_p0),
    .a (op_a_p0),
    .b (op_b_p0),
    .s (dp_s),
    .c (dp_c),
    .o (dp_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prio       <= RST_PRIO;
      op_mode_p0 <= 1'b0;
      op_a_p0    <= '0;
      op_b_p0    <= '0;
      op_id_p0   <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_s      <= '0;
      rsp_c      <= 1'b0;
      rsp_o      <= 1'b0;
    end else begin
      case (state)
        // Request -> p0: capture the granted requester's operation.
        S_IDLE: begin
          if (any_grant) begin
            op_mode_p0 <= sel1 ? req1_mode : req0_mode;
            op_a_p0    <= sel1 ? req1_a    : req0_a;
            op_b_p0    <= sel1 ? req1_b    : req0_b;
            op_id_p0   <= sel1;
            state      <= S_EXEC;
          end
        end
        // p0 -> response registers: latch the datapath result.
        S_EXEC: begin
          rsp_s  <= dp_s;
          rsp_c  <= dp_c;
          rsp_o  <= dp_o;
          rsp_id <= op_id_p0;
          state  <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            prio  <= ~rsp_id;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
